id_ex_stage: RTL and testbench

ID/EX pipeline register and EX-stage operand selection for the 5-stage RV32I pipeline. It latches decoded instructions from ID and exposes `ID_EX_rs1/rs2` to the forwarding unit. It consumes that unit's `forward_A/forward_B` selects to build the ALU operands and store data. It also detects load-use hazards, stalls IF/ID, and inserts bubbles on stall or branch flush.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/operand_fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared across the RV32I pipeline stages.
// Holds the forwarding-select encodings, the ALU control width and the
// ID/EX control bundle together with its all-zero bubble value.
package pipeline_pkg;

    localparam int ALU_CTRL_W = 4;

    // Forwarding selects; 2'b11 is reserved and treated like FWD_RF
    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t BUBBLE = '{
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_ctrl:   {ALU_CTRL_W{1'b0}}
    };

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: picks the freshest copy of one EX operand from the
// register file value, the EX/MEM result or the MEM/WB write-back data.
// The reserved select 2'b11 falls back to the register file value.
module operand_fwd_mux
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] ex_mem_data,
    input  logic [XLEN-1:0] mem_wb_data,
    output logic [XLEN-1:0] fwd_data
);

    // Decode the select; anything unrecognised keeps the register file value
    always_comb begin
        fwd_data = rf_data;
        case (sel)
            FWD_EX_MEM: fwd_data = ex_mem_data;
            FWD_MEM_WB: fwd_data = mem_wb_data;
            FWD_RF:     fwd_data = rf_data;
            default:    fwd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus EX operand selection.
// Latches the decoded instruction, applies the forwarding selects to build
// the ALU operands and store data, and detects load-use hazards (stalling
// IF/ID and inserting a bubble). Flush and stall both load a bubble.
// Optional macro ID_EX_HAZARD_STATS_EN adds free-running 32-bit
// stall/flush/bubble counters as extra outputs.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic [4:0]            id_rd,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  id_MemWrite,
    input  logic                  id_MemtoReg,
    input  logic                  id_ALUSrc,
    input  logic [ALU_CTRL_W-1:0] id_ALUCtrl,
    input  logic [1:0]            forward_A,
    input  logic [1:0]            forward_B,
    input  logic [XLEN-1:0]       ex_mem_alu_result,
    input  logic [XLEN-1:0]       mem_wb_write_data,
    input  logic                  flush,
    output logic [4:0]            ID_EX_rs1,
    output logic [4:0]            ID_EX_rs2,
    output logic [4:0]            ID_EX_rd,
    output logic                  ID_EX_RegWrite,
    output logic                  ID_EX_MemRead,
    output logic                  ID_EX_MemWrite,
    output logic                  ID_EX_MemtoReg,
    output logic [ALU_CTRL_W-1:0] ID_EX_ALUCtrl,
    output logic [XLEN-1:0]       ex_operand_a,
    output logic [XLEN-1:0]       ex_operand_b,
    output logic [XLEN-1:0]       ex_store_data,
    output logic                  stall
`ifdef ID_EX_HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count,
    output logic [31:0]           bubble_count
`endif
);

    import pipeline_pkg::*;

    id_ex_ctrl_t     id_ctrl_s;
    id_ex_ctrl_t     ctrl_r;
    logic [4:0]      rs1_r;
    logic [4:0]      rs2_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] rs1_data_r;
    logic [XLEN-1:0] rs2_data_r;
    logic [XLEN-1:0] imm_r;
    logic            hazard_s;
    logic            stall_s;
    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] operand_b_s;

    // Bundle the decoded controls; an empty ID slot contributes no side effects
    always_comb begin
        id_ctrl_s = BUBBLE;
        if (id_valid) begin
            id_ctrl_s.reg_write  = id_RegWrite;
            id_ctrl_s.mem_read   = id_MemRead;
            id_ctrl_s.mem_write  = id_MemWrite;
            id_ctrl_s.mem_to_reg = id_MemtoReg;
            id_ctrl_s.alu_src    = id_ALUSrc;
            id_ctrl_s.alu_ctrl   = id_ALUCtrl;
        end else begin
            id_ctrl_s = BUBBLE;
        end
    end

    // Load-use: a load in EX whose non-x0 destination feeds the ID instruction
    always_comb begin
        hazard_s = 1'b0;
        if (ctrl_r.mem_read && (rd_r != 5'd0) && id_valid &&
            ((rd_r == id_rs1) || (rd_r == id_rs2))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush discards the ID instruction anyway, so it masks the stall
    assign stall_s = hazard_s & ~flush;

    // Pipeline register: reset, flush and stall all load a bubble
    always_ff @(posedge clk) begin
        if (rst || flush || hazard_s) begin
            ctrl_r     <= BUBBLE;
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            rd_r       <= 5'd0;
            rs1_data_r <= {XLEN{1'b0}};
            rs2_data_r <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
        end else begin
            ctrl_r     <= id_ctrl_s;
            rs1_r      <= id_rs1;
            rs2_r      <= id_rs2;
            rd_r       <= id_rd;
            rs1_data_r <= id_rs1_data;
            rs2_data_r <= id_rs2_data;
            imm_r      <= id_imm;
        end
    end

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .sel         (forward_A),
        .rf_data     (rs1_data_r),
        .ex_mem_data (ex_mem_alu_result),
        .mem_wb_data (mem_wb_write_data),
        .fwd_data    (fwd_a_s)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .sel         (forward_B),
        .rf_data     (rs2_data_r),
        .ex_mem_data (ex_mem_alu_result),
        .mem_wb_data (mem_wb_write_data),
        .fwd_data    (fwd_b_s)
    );

    // Second ALU operand is the immediate for I-type/loads/stores, else rs2
    always_comb begin
        operand_b_s = fwd_b_s;
        if (ctrl_r.alu_src) begin
            operand_b_s = imm_r;
        end else begin
            operand_b_s = fwd_b_s;
        end
    end

    assign ex_operand_a   = fwd_a_s;
    assign ex_operand_b   = operand_b_s;
    assign ex_store_data  = fwd_b_s;
    assign stall          = stall_s;
    assign ID_EX_rs1      = rs1_r;
    assign ID_EX_rs2      = rs2_r;
    assign ID_EX_rd       = rd_r;
    assign ID_EX_RegWrite = ctrl_r.reg_write;
    assign ID_EX_MemRead  = ctrl_r.mem_read;
    assign ID_EX_MemWrite = ctrl_r.mem_write;
    assign ID_EX_MemtoReg = ctrl_r.mem_to_reg;
    assign ID_EX_ALUCtrl  = ctrl_r.alu_ctrl;

`ifdef ID_EX_HAZARD_STATS_EN
    logic        bubble_load_s;
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Any edge that does not latch a real instruction counts as a bubble
    assign bubble_load_s = flush | hazard_s | ~id_valid;

    // Hazard statistics, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= 32'd0;
            flush_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r  <= stall_cnt_r  + {31'd0, stall_s};
            flush_cnt_r  <= flush_cnt_r  + {31'd0, flush};
            bubble_cnt_r <= bubble_cnt_r + {31'd0, bubble_load_s};
        end
    end

    assign stall_count  = stall_cnt_r;
    assign flush_count  = flush_cnt_r;
    assign bubble_count = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// Table-driven forwarding vectors, hand-written hazard/flush/reset
// sequences, then randomized traffic against a slot-level reference model.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc;
    logic [3:0]  id_ALUCtrl;
    logic [1:0]  forward_A, forward_B;
    logic [31:0] ex_mem_alu_result, mem_wb_write_data;
    logic        flush;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
    logic [3:0]  ID_EX_ALUCtrl;
    logic [31:0] ex_operand_a, ex_operand_b, ex_store_data;
    logic        stall;
`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count, bubble_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
        .id_ALUSrc(id_ALUSrc), .id_ALUCtrl(id_ALUCtrl),
        .forward_A(forward_A), .forward_B(forward_B),
        .ex_mem_alu_result(ex_mem_alu_result),
        .mem_wb_write_data(mem_wb_write_data), .flush(flush),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
        .ID_EX_ALUCtrl(ID_EX_ALUCtrl),
        .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
        .ex_store_data(ex_store_data), .stall(stall)
`ifdef ID_EX_HAZARD_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count),
        .bubble_count(bubble_count)
`endif
    );

    // Reference model: contents of the EX slot
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, m2r, as;
        logic [3:0]  alu;
        logic [31:0] d1, d2, imm;
    } slot_t;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        as;
        logic [31:0] d1, d2, imm, exm, mwb;
        logic [31:0] exp_a, exp_b, exp_sd;
    } vec_t;

    slot_t m;
    vec_t  vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic mw, input logic m2r, input logic as,
                          input logic [3:0] alu, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] im);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw; id_MemtoReg = m2r;
        id_ALUSrc = as; id_ALUCtrl = alu;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = im;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_RegWrite"}, {31'd0, ID_EX_RegWrite}, 32'd0);
        chk({tag, "_MemRead"},  {31'd0, ID_EX_MemRead},  32'd0);
        chk({tag, "_MemWrite"}, {31'd0, ID_EX_MemWrite}, 32'd0);
        chk({tag, "_MemtoReg"}, {31'd0, ID_EX_MemtoReg}, 32'd0);
        chk({tag, "_ALUCtrl"},  {28'd0, ID_EX_ALUCtrl},  32'd0);
        chk({tag, "_rd"},       {27'd0, ID_EX_rd},       32'd0);
    endtask

    task automatic chk_slot(input string tag);
        chk({tag, "_rs1"}, {27'd0, ID_EX_rs1}, {27'd0, m.rs1});
        chk({tag, "_rs2"}, {27'd0, ID_EX_rs2}, {27'd0, m.rs2});
        chk({tag, "_rd"},  {27'd0, ID_EX_rd},  {27'd0, m.rd});
        chk({tag, "_ctrl"},
            {24'd0, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUCtrl},
            {24'd0, m.rw, m.mr, m.mw, m.m2r, m.alu});
    endtask

    // A load to x5 followed by a dependent add: exactly one stalled cycle
    task automatic load_use_once();
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 32'd4);
        step();
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd0, 32'd0, 32'd0);
        step();
        step();
    endtask

    initial begin
        logic        v, mr, fl, hz, st;
        logic [4:0]  r1, r2, rd;
        logic [1:0]  fa, fb;
        logic [31:0] exm, mwb, d1, d2, im;
        logic [31:0] opts_a[4];
        logic [31:0] opts_b[4];
        logic [31:0] sc, fc, bc;
        slot_t       nx;

        rst = 1'b1; flush = 1'b0; forward_A = 2'b00; forward_B = 2'b00;
        ex_mem_alu_result = 32'hDEAD_0001; mem_wb_write_data = 32'hDEAD_0002;
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7,
               32'h1234, 32'h5678, 32'h9ABC);

        // Reset: everything reads zero
        step();
        chk_bubble("reset");
        chk("reset_rs1", {27'd0, ID_EX_rs1}, 32'd0);
        chk("reset_op_a", ex_operand_a, 32'd0);
        chk("reset_op_b", ex_operand_b, 32'd0);
        chk("reset_sd", ex_store_data, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
`ifdef ID_EX_HAZARD_STATS_EN
        chk("reset_stall_count", stall_count, 32'd0);
        chk("reset_flush_count", flush_count, 32'd0);
        chk("reset_bubble_count", bubble_count, 32'd0);
`endif
        rst = 1'b0;

        // Forwarding / ALUSrc vectors
        vecs[0] = '{fa:2'b10, fb:2'b01, as:1'b0, d1:32'hA, d2:32'hB, imm:32'h5,
                    exm:32'h11, mwb:32'h22, exp_a:32'h11, exp_b:32'h22, exp_sd:32'h22};
        vecs[1] = '{fa:2'b00, fb:2'b11, as:1'b0, d1:32'hA, d2:32'hB, imm:32'h5,
                    exm:32'h11, mwb:32'h22, exp_a:32'hA, exp_b:32'hB, exp_sd:32'hB};
        vecs[2] = '{fa:2'b01, fb:2'b10, as:1'b1, d1:32'hC, d2:32'hD, imm:32'hFFFF_FFF0,
                    exm:32'h33, mwb:32'h44, exp_a:32'h44, exp_b:32'hFFFF_FFF0, exp_sd:32'h33};
        vecs[3] = '{fa:2'b11, fb:2'b00, as:1'b1, d1:32'h7777, d2:32'h8888, imm:32'h10,
                    exm:32'h55, mwb:32'h66, exp_a:32'h7777, exp_b:32'h10, exp_sd:32'h8888};
        for (int i = 0; i < 4; i++) begin
            forward_A = 2'b00; forward_B = 2'b00;
            set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, vecs[i].as, 4'd2,
                   vecs[i].d1, vecs[i].d2, vecs[i].imm);
            step();
            forward_A = vecs[i].fa; forward_B = vecs[i].fb;
            ex_mem_alu_result = vecs[i].exm; mem_wb_write_data = vecs[i].mwb;
            #1;
            chk($sformatf("vec%0d_op_a", i), ex_operand_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_op_b", i), ex_operand_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_sd", i), ex_store_data, vecs[i].exp_sd);
        end
        forward_A = 2'b00; forward_B = 2'b00;

        // Load-use: one stall, one bubble, then the add with MEM/WB forwarding
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 32'd4);
        step();
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h1, 32'h2, 32'd0);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        step();
        chk("lu_bubble_rw", {31'd0, ID_EX_RegWrite}, 32'd0);
        chk("lu_bubble_stall", {31'd0, stall}, 32'd0);
        step();
        chk("lu_add_rd", {27'd0, ID_EX_rd}, 32'd7);
        chk("lu_add_rw", {31'd0, ID_EX_RegWrite}, 32'd1);
        forward_A = 2'b01; mem_wb_write_data = 32'hCAFE_5555;
        #1;
        chk("lu_fwd_a", ex_operand_a, 32'hCAFE_5555);
        forward_A = 2'b00;

        // Flush together with a load-use hazard
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 32'd4);
        step();
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 32'h1, 32'h2, 32'd0);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        chk_bubble("fl");

        // Load to x0 never stalls
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 32'd4);
        step();
        set_id(1'b1, 5'd0, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd0, 32'd0, 32'd0);
        #1;
        chk("x0_stall", {31'd0, stall}, 32'd0);

        // Load followed by a dependent load
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 32'd4);
        step();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 32'd8);
        #1;
        chk("ll_stall", {31'd0, stall}, 32'd1);
        step();
        chk("ll_bubble_mr", {31'd0, ID_EX_MemRead}, 32'd0);
        chk("ll_stall2", {31'd0, stall}, 32'd0);
        step();
        chk("ll_second_mr", {31'd0, ID_EX_MemRead}, 32'd1);
        chk("ll_second_rd", {27'd0, ID_EX_rd}, 32'd6);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("ll_stall3", {31'd0, stall}, 32'd0);

        // Reset asserted while a stall is pending
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 32'd4);
        step();
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h1, 32'h2, 32'd0);
        #1;
        chk("rs_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_bubble("rs");
        chk("rs_stall", {31'd0, stall}, 32'd0);
        chk("rs_op_a", ex_operand_a, 32'd0);
`ifdef ID_EX_HAZARD_STATS_EN
        chk("rs_stall_count0", stall_count, 32'd0);
        chk("rs_flush_count0", flush_count, 32'd0);
        for (int i = 0; i < 3; i++) load_use_once();
        chk("rs_stall_count3", stall_count, 32'd3);
        chk("rs_flush_count3", flush_count, 32'd0);
`endif

        // Randomized traffic against the slot model
        rst = 1'b1;
        step();
        rst = 1'b0;
        m = '{default: '0};
        sc = 32'd0; fc = 32'd0; bc = 32'd0;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            mr  = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 9) == 0);
            fa  = 2'($urandom_range(0, 3));
            fb  = 2'($urandom_range(0, 3));
            exm = $urandom; mwb = $urandom;
            d1  = $urandom; d2 = $urandom; im = $urandom;
            set_id(v, r1, r2, rd, 1'($urandom_range(0, 1)), mr, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), d1, d2, im);
            flush = fl; forward_A = fa; forward_B = fb;
            ex_mem_alu_result = exm; mem_wb_write_data = mwb;
            #1;
            opts_a = '{m.d1, mwb, exm, m.d1};
            opts_b = '{m.d2, mwb, exm, m.d2};
            hz = m.mr && (m.rd != 5'd0) && v && ((m.rd == r1) || (m.rd == r2));
            st = hz && !fl;
            chk("rnd_stall", {31'd0, stall}, {31'd0, st});
            chk("rnd_op_a", ex_operand_a, opts_a[fa]);
            chk("rnd_op_b", ex_operand_b, m.as ? m.imm : opts_b[fb]);
            chk("rnd_sd", ex_store_data, opts_b[fb]);
            nx = '{default: '0};
            if (!(fl || st)) begin
                nx.rs1 = r1; nx.rs2 = r2; nx.rd = rd;
                nx.d1 = d1; nx.d2 = d2; nx.imm = im;
                if (v) begin
                    nx.rw = id_RegWrite; nx.mr = id_MemRead; nx.mw = id_MemWrite;
                    nx.m2r = id_MemtoReg; nx.as = id_ALUSrc; nx.alu = id_ALUCtrl;
                end
            end
            if (st) sc = sc + 32'd1;
            if (fl) fc = fc + 32'd1;
            if (fl || st || !v) bc = bc + 32'd1;
            m = nx;
            step();
            chk_slot("rnd");
        end
`ifdef ID_EX_HAZARD_STATS_EN
        chk("rnd_stall_count", stall_count, sc);
        chk("rnd_flush_count", flush_count, fc);
        chk("rnd_bubble_count", bubble_count, bc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
